// File: rtl/ddram_wr_fifo_pkg.sv
// Shared DDRAM port constants and small helpers for the DDRAM write-posting buffer.
package ddram_wr_fifo_pkg;

    localparam int         DDRAM_AW     = 29;
    localparam int         DDRAM_DW     = 64;
    localparam int         DDRAM_BEW    = DDRAM_DW / 8;
    localparam logic [7:0] DDRAM_BURST1 = 8'd1;

    // Counter that sticks at all-ones so a long overflow storm stays visible.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ddram_wr_fifo_mem.sv
// Entry storage for ddram_wr_fifo: one write port with per-byte data enables,
// asynchronous reads of the head entry and of the tail entry.
module ddram_wr_fifo_mem #(
    parameter int AW         = 29,
    parameter int DW         = 64,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DW-1:0]         wr_din,
    input  logic [DW/8-1:0]       wr_be,
    input  logic [DW/8-1:0]       lane_en,
    input  logic [DEPTH_LOG2-1:0] head_ptr,
    input  logic [DEPTH_LOG2-1:0] tail_ptr,
    output logic [AW-1:0]         head_addr,
    output logic [DW-1:0]         head_din,
    output logic [DW/8-1:0]       head_be,
    output logic [AW-1:0]         tail_addr,
    output logic [DW/8-1:0]       tail_be
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int BEW   = DW / 8;

    logic [AW-1:0]  addr_mem [DEPTH];
    logic [BEW-1:0] be_mem   [DEPTH];

    // Address and byte-enable fields are rewritten on every write; on a merge
    // the caller supplies the same address and the OR-ed enables.
    always_ff @(posedge clk) begin
        if (we) begin
            addr_mem[waddr] <= wr_addr;
            be_mem[waddr]   <= wr_be;
        end
    end

    assign head_addr = addr_mem[head_ptr];
    assign head_be   = be_mem[head_ptr];
    assign tail_addr = addr_mem[tail_ptr];
    assign tail_be   = be_mem[tail_ptr];

    for (genvar l = 0; l < BEW; l++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we && lane_en[l])
                lane_mem[waddr] <= wr_din[l*8 +: 8];
        end

        assign head_din[l*8 +: 8] = lane_mem[head_ptr];
    end

endmodule

// File: rtl/ddram_wr_fifo.sv
// Write-posting FIFO in front of the DDRAM Avalon write port; drops and counts writes on overflow.
// Optional write merging into the tail entry is enabled by defining DDRAM_WR_MERGE_EN.
module ddram_wr_fifo
    import ddram_wr_fifo_pkg::*;
#(
    parameter int AW         = DDRAM_AW,
    parameter int DW         = DDRAM_DW,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_we,
    input  logic [AW-1:0]         in_addr,
    input  logic [DW-1:0]         in_din,
    input  logic [DW/8-1:0]       in_be,
    output logic                  in_full,
    output logic [DEPTH_LOG2:0]   level,
    output logic [15:0]           ovf_cnt,
    input  logic                  DDRAM_BUSY,
    output logic                  DDRAM_WE,
    output logic [AW-1:0]         DDRAM_ADDR,
    output logic [DW-1:0]         DDRAM_DIN,
    output logic [DW/8-1:0]       DDRAM_BE,
    output logic [7:0]            DDRAM_BURSTCNT,
    output logic                  DDRAM_RD
);

    localparam int                  BEW     = DW / 8;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] ONE_C   = (DEPTH_LOG2+1)'(1);

    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, tail_ptr, mem_waddr;
    logic [DEPTH_LOG2:0]   count, count_nxt;
    logic                  xfer_done, out_free, pop, push, merge, drop;
    logic                  mem_we;
    logic [BEW-1:0]        mem_be, lane_en;
    logic [AW-1:0]         head_addr, tail_addr;
    logic [DW-1:0]         head_din;
    logic [BEW-1:0]        head_be, tail_be;

    assign tail_ptr       = wr_ptr - DEPTH_LOG2'(1);
    assign level          = count;
    assign DDRAM_BURSTCNT = DDRAM_BURST1;
    assign DDRAM_RD       = 1'b0;

    ddram_wr_fifo_mem #(
        .AW         (AW),
        .DW         (DW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk       (clk),
        .we        (mem_we),
        .waddr     (mem_waddr),
        .wr_addr   (in_addr),
        .wr_din    (in_din),
        .wr_be     (mem_be),
        .lane_en   (lane_en),
        .head_ptr  (rd_ptr),
        .tail_ptr  (tail_ptr),
        .head_addr (head_addr),
        .head_din  (head_din),
        .head_be   (head_be),
        .tail_addr (tail_addr),
        .tail_be   (tail_be)
    );

`ifdef DDRAM_WR_MERGE_EN
    // The tail is only consumed by this cycle's pop when it is the sole entry.
    assign merge = in_we && (count != '0) && (in_addr == tail_addr) &&
                   !(pop && (count == ONE_C));
`else
    logic tail_unused;
    assign merge       = 1'b0;
    assign tail_unused = ^{tail_addr, tail_be};
`endif

    always_comb begin
        xfer_done = DDRAM_WE && !DDRAM_BUSY;
        out_free  = !DDRAM_WE || xfer_done;
        pop       = out_free && (count != '0);
        push      = in_we && !merge && ((count != DEPTH_C) || pop);
        drop      = in_we && !merge && !push;

        mem_we    = push || merge;
        mem_waddr = merge ? tail_ptr : wr_ptr;
        mem_be    = merge ? (tail_be | in_be) : in_be;
        lane_en   = merge ? in_be : {BEW{1'b1}};

        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + ONE_C;
            2'b01:   count_nxt = count - ONE_C;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_full    <= 1'b0;
            ovf_cnt    <= '0;
            DDRAM_WE   <= 1'b0;
            DDRAM_ADDR <= '0;
            DDRAM_DIN  <= '0;
            DDRAM_BE   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            count   <= count_nxt;
            in_full <= (count_nxt == DEPTH_C);
            if (drop)
                ovf_cnt <= sat_inc16(ovf_cnt);

            // Output register reloads only when idle or its beat was just accepted.
            if (out_free) begin
                if (pop) begin
                    DDRAM_WE   <= 1'b1;
                    DDRAM_ADDR <= head_addr;
                    DDRAM_DIN  <= head_din;
                    DDRAM_BE   <= head_be;
                end else begin
                    DDRAM_WE   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddram_wr_fifo.sv
// Scoreboard bench for ddram_wr_fifo: expected DDRAM beats are queued at issue, a monitor checks completions.
module tb_ddram_wr_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_we;
    logic [28:0] in_addr;
    logic [63:0] in_din;
    logic [7:0]  in_be;
    logic        in_full;
    logic [4:0]  level;
    logic [15:0] ovf_cnt;
    logic        DDRAM_BUSY;
    logic        DDRAM_WE;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic [7:0]  DDRAM_BURSTCNT;
    logic        DDRAM_RD;

    always #5 clk = ~clk;

    ddram_wr_fifo dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_we          (in_we),
        .in_addr        (in_addr),
        .in_din         (in_din),
        .in_be          (in_be),
        .in_full        (in_full),
        .level          (level),
        .ovf_cnt        (ovf_cnt),
        .DDRAM_BUSY     (DDRAM_BUSY),
        .DDRAM_WE       (DDRAM_WE),
        .DDRAM_ADDR     (DDRAM_ADDR),
        .DDRAM_DIN      (DDRAM_DIN),
        .DDRAM_BE       (DDRAM_BE),
        .DDRAM_BURSTCNT (DDRAM_BURSTCNT),
        .DDRAM_RD       (DDRAM_RD)
    );

    typedef struct packed {
        logic [28:0] a;
        logic [63:0] d;
        logic [7:0]  be;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // A beat is accepted at the next posedge when WE is high and BUSY is low.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && DDRAM_WE === 1'b1 && DDRAM_BUSY === 1'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL beat_extra got_addr=%h want=none", DDRAM_ADDR);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_addr", 64'(DDRAM_ADDR), 64'(mon_e.a));
                chk("beat_din",  DDRAM_DIN,       mon_e.d);
                chk("beat_be",   64'(DDRAM_BE),   64'(mon_e.be));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [28:0] a, input logic [63:0] d, input logic [7:0] be,
                         input bit expect_issue);
        in_we   = 1'b1;
        in_addr = a;
        in_din  = d;
        in_be   = be;
        if (expect_issue)
            exp_q.push_back('{a: a, d: d, be: be});
        tick();
    endtask

    task automatic expect_beat(input logic [28:0] a, input logic [63:0] d, input logic [7:0] be);
        exp_q.push_back('{a: a, d: d, be: be});
    endtask

    task automatic drain(input string nm, input int budget);
        bit done;
        done       = 1'b0;
        in_we      = 1'b0;
        DDRAM_BUSY = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (exp_q.size() == 0 && DDRAM_WE == 1'b0 && level == 5'd0)
                done = 1'b1;
        end
        chk(nm, 64'(done), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        in_we      = 1'b0;
        in_addr    = '0;
        in_din     = '0;
        in_be      = '0;
        DDRAM_BUSY = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        @(negedge clk);
        chk("rst_we",    64'(DDRAM_WE),       64'd0);
        chk("rst_level", 64'(level),          64'd0);
        chk("rst_full",  64'(in_full),        64'd0);
        chk("rst_ovf",   64'(ovf_cnt),        64'd0);
        chk("rst_addr",  64'(DDRAM_ADDR),     64'd0);
        chk("burstcnt",  64'(DDRAM_BURSTCNT), 64'd1);
        chk("rd_const",  64'(DDRAM_RD),       64'd0);

        // single write: WE rises one edge after the write is sampled
        tick();
        drive(29'h1200000, 64'hA5, 8'h0F, 1'b1);
        in_we = 1'b0;
        @(negedge clk);
        chk("t1_we_k",    64'(DDRAM_WE), 64'd0);
        chk("t1_level_k", 64'(level),    64'd1);
        tick();
        @(negedge clk);
        chk("t1_we_k1",   64'(DDRAM_WE),       64'd1);
        chk("t1_burst",   64'(DDRAM_BURSTCNT), 64'd1);
        tick();
        @(negedge clk);
        chk("t1_we_k2",   64'(DDRAM_WE), 64'd0);

        // stalled output register holds A0 stable
        tick();
        DDRAM_BUSY = 1'b1;
        drive(29'h0000100, 64'h1000_0000_0000_00A0, 8'hFF, 1'b1);
        drive(29'h0000101, 64'h1000_0000_0000_00A1, 8'h3C, 1'b1);
        drive(29'h0000102, 64'h1000_0000_0000_00A2, 8'h81, 1'b1);
        in_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_we_hold",   64'(DDRAM_WE),   64'd1);
            chk("t2_addr_hold", 64'(DDRAM_ADDR), 64'h100);
            tick();
        end
        @(negedge clk);
        chk("t2_level", 64'(level), 64'd2);
        drain("t2_drain", 20);
        chk("t2_level_end", 64'(level), 64'd0);

        // overflow: 1 in output register, 16 queued, 3 dropped
        DDRAM_BUSY = 1'b1;
        for (int i = 0; i < 20; i++)
            drive(29'h2000 + 29'(i), {32'hD000_0000 + 32'(i), 32'(i)}, 8'hFF, i < 17);
        in_we = 1'b0;
        @(negedge clk);
        chk("t3_level", 64'(level),      64'd16);
        chk("t3_full",  64'(in_full),    64'd1);
        chk("t3_ovf",   64'(ovf_cnt),    64'd3);
        chk("t3_head",  64'(DDRAM_ADDR), 64'h2000);

        // full with a completing beat: the push is accepted
        tick();
        DDRAM_BUSY = 1'b0;
        drive(29'h2100, 64'hCAFE_0000_0000_0020, 8'h55, 1'b1);
        DDRAM_BUSY = 1'b1;
        in_we      = 1'b0;
        @(negedge clk);
        chk("t4_level", 64'(level),      64'd16);
        chk("t4_ovf",   64'(ovf_cnt),    64'd3);
        chk("t4_full",  64'(in_full),    64'd1);
        chk("t4_head",  64'(DDRAM_ADDR), 64'h2001);
        drain("t3_drain", 60);
        chk("t4_full_end", 64'(in_full), 64'd0);

        // two writes to the same address behind a stalled beat
        DDRAM_BUSY = 1'b1;
        drive(29'h0300000, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
        drive(29'h0300040, 64'h1111_1111_1111_1111, 8'h0F, 1'b0);
        drive(29'h0300040, 64'h2222_2222_2222_2222, 8'hF0, 1'b0);
        in_we = 1'b0;
`ifdef DDRAM_WR_MERGE_EN
        expect_beat(29'h0300040, 64'h2222_2222_1111_1111, 8'hFF);
        @(negedge clk);
        chk("t5_level", 64'(level), 64'd1);
`else
        expect_beat(29'h0300040, 64'h1111_1111_1111_1111, 8'h0F);
        expect_beat(29'h0300040, 64'h2222_2222_2222_2222, 8'hF0);
        @(negedge clk);
        chk("t5_level", 64'(level), 64'd2);
`endif
        chk("t5_ovf", 64'(ovf_cnt), 64'd3);
        drain("t5_drain", 20);

        // reset abandons the in-flight beat and queued entries
        DDRAM_BUSY = 1'b1;
        for (int i = 0; i < 6; i++)
            drive(29'h0400000 + 29'(i), 64'(i) + 64'hBEEF_0000, 8'hFF, 1'b0);
        in_we = 1'b0;
        @(negedge clk);
        chk("t6_level_pre", 64'(level),    64'd5);
        chk("t6_we_pre",    64'(DDRAM_WE), 64'd1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_we",    64'(DDRAM_WE), 64'd0);
        chk("t6_level", 64'(level),    64'd0);
        chk("t6_ovf",   64'(ovf_cnt),  64'd0);
        chk("t6_full",  64'(in_full),  64'd0);
        tick();
        DDRAM_BUSY = 1'b0;
        drive(29'h0500000, 64'hFEED_FACE_0000_0006, 8'hC3, 1'b1);
        drain("t6_drain", 10);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
